// File: rtl/srlatch_lock_ctrl_if.sv
// Requester/latch bundle for the round-robin lock controller.
// The master side is the requesters plus the latch readback; the slave side is the controller.
interface srlatch_lock_ctrl_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] rel;
    logic [NREQ-1:0] grant;
    logic            busy;
    logic            err;
    logic            latch_s;
    logic            latch_r;
    logic            latch_q;

    modport master (
        output req, rel, latch_q,
        input  grant, busy, err, latch_s, latch_r
    );

    modport slave (
        input  req, rel, latch_q,
        output grant, busy, err, latch_s, latch_r
    );
endinterface

// File: rtl/srlatch_lock_ctrl.sv
// Round-robin lock controller that owns the set/reset inputs of an external SR latch
// and only grants or frees the lock once the latch readback confirms the transition.
module srlatch_lock_ctrl #(
    parameter int NREQ     = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    srlatch_lock_ctrl_if.slave bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(MAX_WAIT - 1);
    localparam logic [OW-1:0] LAST_IDX   = OW'(NREQ - 1);

    typedef enum logic [1:0] {
        CLR  = 2'd0,
        IDLE = 2'd1,
        SET  = 2'd2,
        HELD = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            err_q, err_d;
    logic [NREQ-1:0] grant_q;
    logic            busy_q;
    logic            latch_s_q;
    logic            latch_r_q;

    // First requester at or after the round-robin start, wrapping around.
    function automatic logic [OW-1:0] pick_owner(input logic [NREQ-1:0] r,
                                                 input logic [OW-1:0]   start);
        logic [OW-1:0] sel;
        logic          found;
        int            idx;
        sel   = start;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(start) + i) % NREQ;
            if (!found && r[idx]) begin
                sel   = OW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] cur);
        return (cur == LAST_IDX) ? '0 : cur + OW'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        err_d   = err_q;
        case (state_q)
            CLR: begin
                if (!bus.latch_q) begin
                    state_d = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            IDLE: begin
                if (|bus.req) begin
                    owner_d = pick_owner(bus.req, ptr_q);
                    state_d = SET;
                end
            end
            SET: begin
                if (bus.latch_q) begin
                    state_d = HELD;
                end else if (timer_q == TIMER_LAST) begin
                    // A latch that never sets must not hand out a lock; clear it and retry later.
                    err_d   = 1'b1;
                    state_d = CLR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            HELD: begin
                if (bus.rel[owner_q]) begin
                    state_d = CLR;
                    ptr_d   = next_idx(owner_q);
                end
            end
            default: state_d = CLR;
        endcase
        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= CLR;
            owner_q   <= '0;
            ptr_q     <= '0;
            timer_q   <= '0;
            err_q     <= 1'b0;
            grant_q   <= '0;
            busy_q    <= 1'b1;
            latch_s_q <= 1'b0;
            latch_r_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            grant_q   <= (state_d == HELD) ? (NREQ'(1) << owner_d) : '0;
            busy_q    <= (state_d != IDLE);
            latch_s_q <= (state_d == SET);
            latch_r_q <= (state_d == CLR);
        end
    end

    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.err     = err_q;
    assign bus.latch_s = latch_s_q;
    assign bus.latch_r = latch_r_q;
endmodule

// File: tb/tb_srlatch_lock_ctrl.sv
// Bench for srlatch_lock_ctrl: directed scenarios plus randomized traffic against a
// behavioural lock model, with a transparent SR latch that can be forced stuck.
module tb_srlatch_lock_ctrl;
    localparam int NREQ     = 4;
    localparam int MAX_WAIT = 8;

    localparam int PH_CLEAR = 0;
    localparam int PH_IDLE  = 1;
    localparam int PH_SET   = 2;
    localparam int PH_HELD  = 3;

    logic clk;
    logic reset_n;
    logic stuck0;
    logic stuck1;
    logic mem;

    int tests_run;
    int tests_failed;

    srlatch_lock_ctrl_if #(.NREQ(NREQ)) bus ();

    srlatch_lock_ctrl #(.NREQ(NREQ), .MAX_WAIT(MAX_WAIT)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transparent latch: set dominates, reset clears, otherwise hold.
    assign bus.latch_q = stuck0 ? 1'b0 : stuck1 ? 1'b1 :
                         bus.latch_s ? 1'b1 : bus.latch_r ? 1'b0 : mem;
    always @(posedge clk) mem <= bus.latch_q;

    // Behavioural model of the lock
    int m_phase;
    int m_owner;
    int m_ptr;
    int m_waited;
    logic m_err;

    function automatic int model_pick(input logic [NREQ-1:0] r, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return start;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_phase  <= PH_CLEAR;
            m_owner  <= 0;
            m_ptr    <= 0;
            m_waited <= 0;
            m_err    <= 1'b0;
        end else begin
            case (m_phase)
                PH_CLEAR: begin
                    if (bus.latch_q == 1'b0) begin
                        m_phase <= PH_IDLE; m_waited <= 0;
                    end else if (m_waited + 1 == MAX_WAIT) begin
                        m_phase <= PH_IDLE; m_waited <= 0; m_err <= 1'b1;
                    end else begin
                        m_waited <= m_waited + 1;
                    end
                end
                PH_IDLE: begin
                    if (bus.req != '0) begin
                        m_owner <= model_pick(bus.req, m_ptr);
                        m_phase <= PH_SET; m_waited <= 0;
                    end
                end
                PH_SET: begin
                    if (bus.latch_q == 1'b1) begin
                        m_phase <= PH_HELD; m_waited <= 0;
                    end else if (m_waited + 1 == MAX_WAIT) begin
                        m_phase <= PH_CLEAR; m_waited <= 0; m_err <= 1'b1;
                    end else begin
                        m_waited <= m_waited + 1;
                    end
                end
                default: begin
                    if (bus.rel[m_owner]) begin
                        m_phase <= PH_CLEAR; m_waited <= 0;
                        m_ptr   <= (m_owner + 1) % NREQ;
                    end
                end
            endcase
        end
    end

    logic [NREQ-1:0] exp_grant;
    assign exp_grant = (m_phase == PH_HELD) ? (NREQ'(1) << m_owner) : '0;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.req = '0;
        bus.rel = '0;
        stuck0  = 1'b0;
        stuck1  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.req = '0;
        bus.rel = '0;
        stuck0  = 1'b0;
        stuck1  = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({bus.latch_r, bus.latch_s, bus.busy, bus.err, bus.grant} !== {4'b1010, 4'b0000}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got r=%b s=%b busy=%b err=%b grant=%b want r=1 s=0 busy=1 err=0 grant=0000",
                     bus.latch_r, bus.latch_s, bus.busy, bus.err, bus.grant);
        end
        reset_n = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({bus.busy, bus.latch_r, bus.latch_s} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_to_idle: got busy=%b r=%b s=%b want 0 0 0", bus.busy, bus.latch_r, bus.latch_s);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0001;
        tick();
        bus.req = '0;
        tests_run++;
        if ({bus.latch_s, bus.latch_r, bus.grant} !== {2'b10, 4'b0000}) begin
            tests_failed++;
            $display("FAIL single_set: got s=%b r=%b grant=%b want s=1 r=0 grant=0000", bus.latch_s, bus.latch_r, bus.grant);
        end
        tick();
        tests_run++;
        if ({bus.latch_s, bus.grant} !== {1'b0, 4'b0001}) begin
            tests_failed++;
            $display("FAIL single_grant: got s=%b grant=%b want s=0 grant=0001", bus.latch_s, bus.grant);
        end
        bus.rel = 4'b0001;
        tick();
        bus.rel = '0;
        tests_run++;
        if ({bus.latch_r, bus.grant, bus.busy} !== {1'b1, 4'b0000, 1'b1}) begin
            tests_failed++;
            $display("FAIL single_clear: got r=%b grant=%b busy=%b want r=1 grant=0000 busy=1", bus.latch_r, bus.grant, bus.busy);
        end
        tick();
        tests_run++;
        if ({bus.latch_r, bus.grant, bus.busy} !== {1'b0, 4'b0000, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_idle: got r=%b grant=%b busy=%b want r=0 grant=0000 busy=0", bus.latch_r, bus.grant, bus.busy);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] want;
        int n;
        do_reset();
        bus.req = '1;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (bus.grant == '0 && n < 20) begin
                tick();
                n++;
            end
            want = NREQ'(1) << (i % NREQ);
            tests_run++;
            if (bus.grant !== want) begin
                tests_failed++;
                $display("FAIL rr_grant%0d: got %b want %b", i, bus.grant, want);
            end
            bus.rel = bus.grant;
            tick();
            bus.rel = '0;
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_foreign_release();
        logic held_ok;
        do_reset();
        bus.req = 4'b0100;
        tick();
        bus.req = '0;
        tick();
        bus.rel = 4'b0001;
        tick();
        bus.rel = '0;
        held_ok = (bus.grant === 4'b0100);
        tick();
        held_ok = held_ok && (bus.grant === 4'b0100);
        tests_run++;
        if (!held_ok) begin
            tests_failed++;
            $display("FAIL foreign_rel: got grant=%b want 0100", bus.grant);
        end
        bus.rel = 4'b0100;
        tick();
        bus.rel = '0;
        tick();
        tests_run++;
        if ({bus.grant, bus.busy} !== {4'b0000, 1'b0}) begin
            tests_failed++;
            $display("FAIL owner_rel: got grant=%b busy=%b want 0000 0", bus.grant, bus.busy);
        end
    endtask

    task automatic test_stuck_latch();
        logic saw_grant;
        logic early_err;
        do_reset();
        stuck0  = 1'b1;
        bus.req = 4'b0001;
        tick();
        bus.req = '0;
        saw_grant = 1'b0;
        early_err = 1'b0;
        for (int i = 1; i < MAX_WAIT; i++) begin
            tick();
            saw_grant = saw_grant | (bus.grant != '0);
            early_err = early_err | bus.err | ~bus.latch_s;
        end
        tests_run++;
        if (early_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL set_wait: got early err/drop=%b want 0", early_err);
        end
        tick();
        tests_run++;
        if ({bus.err, bus.latch_r, bus.latch_s, bus.grant, saw_grant} !== {3'b110, 4'b0000, 1'b0}) begin
            tests_failed++;
            $display("FAIL set_timeout: got err=%b r=%b s=%b grant=%b saw_grant=%b want 1 1 0 0000 0",
                     bus.err, bus.latch_r, bus.latch_s, bus.grant, saw_grant);
        end
        stuck0 = 1'b0;
        tick();
        tests_run++;
        if ({bus.busy, bus.err} !== 2'b01) begin
            tests_failed++;
            $display("FAIL set_timeout_idle: got busy=%b err=%b want 0 1", bus.busy, bus.err);
        end
        bus.req = 4'b0001;
        tick();
        bus.req = '0;
        tick();
        bus.rel = 4'b0001;
        stuck1  = 1'b1;
        tick();
        bus.rel = '0;
        for (int i = 1; i < MAX_WAIT; i++) tick();
        tests_run++;
        if ({bus.busy, bus.latch_r, bus.err} !== 3'b111) begin
            tests_failed++;
            $display("FAIL clr_wait: got busy=%b r=%b err=%b want 1 1 1", bus.busy, bus.latch_r, bus.err);
        end
        tick();
        tests_run++;
        if ({bus.busy, bus.latch_r, bus.err} !== 3'b001) begin
            tests_failed++;
            $display("FAIL clr_timeout: got busy=%b r=%b err=%b want 0 0 1", bus.busy, bus.latch_r, bus.err);
        end
        stuck1 = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        int n;
        do_reset();
        bus.req = 4'b0010;
        tick();
        tick();
        bus.req = '0;
        tests_run++;
        if (bus.grant !== 4'b0010) begin
            tests_failed++;
            $display("FAIL mid_hold_grant: got %b want 0010", bus.grant);
        end
        reset_n = 1'b0;
        tick();
        tests_run++;
        if ({bus.grant, bus.latch_r} !== {4'b0000, 1'b1}) begin
            tests_failed++;
            $display("FAIL mid_hold_reset: got grant=%b r=%b want 0000 1", bus.grant, bus.latch_r);
        end
        reset_n = 1'b1;
        bus.req = '1;
        n = 0;
        while (bus.grant == '0 && n < 20) begin
            tick();
            n++;
        end
        bus.req = '0;
        tests_run++;
        if (bus.grant !== 4'b0001) begin
            tests_failed++;
            $display("FAIL mid_hold_ptr: got %b want 0001", bus.grant);
        end
        bus.rel = bus.grant;
        tick();
        bus.rel = '0;
        tick();
    endtask

    task automatic test_random();
        int stuck_left;
        int bad;
        logic [NREQ+3:0] got, want;
        do_reset();
        stuck_left = 0;
        bad = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            bus.req = ($urandom_range(0, 2) == 0) ? NREQ'($urandom) : '0;
            bus.rel = NREQ'($urandom) & NREQ'($urandom);
            if (bus.grant != '0 && $urandom_range(0, 2) == 0) bus.rel = bus.rel | bus.grant;
            if (stuck_left > 0) begin
                stuck_left--;
                if (stuck_left == 0) begin
                    stuck0 = 1'b0;
                    stuck1 = 1'b0;
                end
            end else if ($urandom_range(0, 59) == 0) begin
                stuck_left = $urandom_range(1, 12);
                if ($urandom_range(0, 1) == 0) stuck0 = 1'b1;
                else stuck1 = 1'b1;
            end
            tick();
            got  = {bus.grant, bus.busy, bus.err, bus.latch_s, bus.latch_r};
            want = {exp_grant, m_phase != PH_IDLE, m_err, m_phase == PH_SET, m_phase == PH_CLEAR};
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                if (bad < 10) $display("FAIL rand_cyc%0d: got grant/busy/err/s/r=%b want %b", cyc, got, want);
                bad++;
            end
            tests_run++;
            if ((bus.latch_s & bus.latch_r) !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand_sr_excl%0d: got s=%b r=%b want not both", cyc, bus.latch_s, bus.latch_r);
            end
        end
        stuck0 = 1'b0;
        stuck1 = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n = 1'b0;
        stuck0  = 1'b0;
        stuck1  = 1'b0;
        mem     = 1'b1;
        bus.req = '0;
        bus.rel = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_foreign_release();
        test_stuck_latch();
        test_reset_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/srlatch_lock_ctrl.md
# srlatch_lock_ctrl

Round-robin lock controller that shares one set/reset flag (an external SR latch) among NREQ requesters. It arbitrates acquire requests and sequences the latch's `s`/`r` inputs. It waits for the latch's `q` readback to confirm each transition before granting or freeing the lock, and flags a sticky error if the latch fails to respond. It sits between requesting agents and the latch, and is the only driver of the latch's inputs.

## Interface
- NREQ, 4, number of requesters (2..16)
- MAX_WAIT, 8, cycles allowed for `latch_q` to confirm a set or clear (≥2)
- clk  input  1  clock; all state changes on rising edge
- reset_n  input  1  synchronous, active-low reset
- req  input  NREQ  acquire request per requester, level-sensitive
- rel  input  NREQ  release strobe per requester; only the owner's bit is honoured
- grant  output  NREQ  one-hot owner indication; all zero when the lock is not held
- busy  output  1  high in every state except IDLE
- err  output  1  sticky: latch failed to confirm within MAX_WAIT cycles
- latch_s  output  1  drives latch set input
- latch_r  output  1  drives latch reset input
- latch_q  input  1  latch output readback

## Operation
- States: CLR, IDLE, SET, HELD. Outputs are decoded from state (Moore).
  - latch_r=1 only in CLR.
  - latch_s=1 only in SET.
  - grant=onehot(owner) only in HELD.
  - busy = (state != IDLE).
- Registers:
  - state
  - owner (clog2 NREQ bits)
  - ptr, the round-robin start (clog2 NREQ bits)
  - timer (clog2 MAX_WAIT bits)
  - err
- Reset (reset_n=0 at edge):
  - state←CLR, owner←0, ptr←0, timer←0, err←0.
  - After that edge: latch_r=1, latch_s=0, grant=0, busy=1, err=0.
  - Every startup therefore clears the latch.
- CLR:
  - latch_q=0 → IDLE.
  - Otherwise timer++; when timer==MAX_WAIT-1 and latch_q still 1 → err←1, go to IDLE.
- IDLE:
  - If any req bit is set, owner←first set bit scanning ptr, ptr+1, …, wrapping modulo NREQ; then → SET.
  - If no req bit is set, stay in IDLE.
- SET:
  - latch_q=1 → HELD.
  - Timeout rule as in CLR; on timeout err←1 and → CLR, with no grant issued.
- HELD:
  - rel[owner]=1 → CLR, and ptr←(owner+1) mod NREQ.
  - rel bits from non-owners are ignored.
  - req bits are ignored.
- timer clears on every state change.
- err stays set until reset; the controller keeps operating while err=1.
- latch_s and latch_r are never both 1.

## Timing
- Latch model is transparent: latch_q follows s/r in the same cycle.
- Acquire: req seen in IDLE at edge t → SET during cycle t+1 → HELD and grant asserted at edge t+2. Minimum acquire latency is 2 cycles.
- Release: rel[owner] at edge t → CLR during t+1 → IDLE at t+2. The earliest next grant is at t+4.
- Simultaneous req and rel from the owner in HELD: the release wins. Ptr advances past the owner, so the owner's renewed req has lowest priority at the next IDLE.
- A req that drops while in SET does not cancel the acquire. Grant is still issued, and the owner must release.
- Timeout: err rises at the edge ending the MAX_WAIT-th waiting cycle. A timeout in SET returns to CLR; a timeout in CLR proceeds to IDLE.
- Reset asserted mid-HELD: grant drops at the next edge and the controller re-clears the latch.
- ptr wraps from NREQ-1 to 0.

## Test plan
- Reset then release, with NREQ=4, MAX_WAIT=8 and a transparent latch model:
  - Stimulus: hold reset_n=0 for 2 cycles, then release.
  - Required: latch_r=1, busy=1, grant=0000 after reset; IDLE and busy=0 by the second cycle after release.
- Single acquire/release:
  - Stimulus: req=0001.
  - Required: latch_s=1 for one cycle, then grant=0001 two cycles after req.
  - Stimulus: rel=0001.
  - Required: latch_r=1 for one cycle, grant=0000, busy=0 two cycles later.
- Round-robin:
  - Stimulus: req=1111 held, with each owner releasing on its first HELD cycle.
  - Required: grant sequence 0001, 0010, 0100, 1000, 0001.
- Foreign release:
  - Stimulus: while owner=2, pulse rel=0001.
  - Required: grant stays 0100.
  - Stimulus: then rel=0100.
  - Required: the lock is freed.
- Stuck latch:
  - Stimulus: force latch_q=0 during SET.
  - Required: err=1 after 8 waiting cycles, no grant issued, state returns through CLR to IDLE.
  - Stimulus: force latch_q=1 during CLR.
  - Required: err stays 1 and the controller reaches IDLE.
- Reset mid-hold:
  - Stimulus: assert reset_n=0 while grant=0010.
  - Required: grant=0000 and latch_r=1 next edge; ptr=0 afterwards, so req=1111 grants 0001 first.
